pipelined_cla_adder: RTL and testbench
======================================

Name: pipelined_cla_adder

Overview:
- Parametrised, pipelined carry-lookahead adder/subtractor.
- Successor to the fixed combinational 4/16/64-bit lookahead adders. Adds configurable width, configurable pipeline depth, a subtract mode, status flags and a valid/ready handshake with backpressure.
- Sits between operand sources, such as the ALU issue stage, and the result writeback.
- Accepts one operation per cycle at full throughput.

Parameters:
- WIDTH, 64: operand and result width in bits. Must be a multiple of SEGS*4.
- SEGS, 4: number of pipeline segments. Segment width SEG_W = WIDTH/SEGS. Latency is SEGS cycles.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  an operation is presented.
- in_ready  out  1  block accepts the operation this cycle.
- a  in  WIDTH  operand A, unsigned or two's complement.
- b  in  WIDTH  operand B.
- carry_in  in  1  carry for add; borrow for subtract.
- sub  in  1  0: sum = a + b + carry_in. 1: sum = a - b - carry_in.
- out_valid  out  1  a result is presented.
- out_ready  in  1  downstream accepts the result.
- sum  out  WIDTH  result, modulo 2^WIDTH.
- carry_out  out  1  raw carry out of the MSB. In subtract mode, 1 means no borrow.
- overflow  out  1  signed overflow: carry into MSB XOR carry out of MSB.
- zero  out  1  sum == 0.

Behaviour:
- Operand preprocessing at issue:
  - b_eff = sub ? ~b : b
  - cin_eff = sub ? ~carry_in : carry_in
- Pipeline structure: SEGS stages. Stage k holds:
  - valid bit v[k]
  - completed low result bits [k*SEG_W-1:0]
  - remaining operand bits of a and b_eff above that point
  - registered carry into segment k
- Stage work: stage k adds segment k with a SEG_W-bit lookahead. Inside the segment, carries use 4-bit groups with group P/G and a second lookahead level; no ripple across groups. Only the segment carry crosses a register.
- Latency: an accepted operation appears on out_valid exactly SEGS cycles after the acceptance edge, provided no stall occurs. The last stage register is the output register.
- Advance rule, evaluated from the last stage backward:
  - adv[SEGS-1] = ~v[SEGS-1] | out_ready
  - adv[k] = ~v[k] | adv[k+1]
  - in_ready = adv[0]. It depends combinationally on out_ready; this is intentional.
- Transfers:
  - Input transfer when in_valid & in_ready.
  - Output transfer when out_valid & out_ready.
  - A stage with adv = 1 loads from its predecessor and takes the predecessor's valid.
  - A bubble loads v = 0, and its data registers may update freely.
- Stall: while out_valid & ~out_ready, sum and all flags hold stable. The pipeline fills bubbles behind the stall, buffering up to SEGS operations, then in_ready = 0.
- Simultaneous in and out transfer with a full pipe: both occur; throughput is 1 per cycle.
- Ordering: results leave in issue order; no drop or duplication under any out_ready pattern.
- Flags are computed in the final stage from the MSB segment and registered with sum:
  - zero uses the full WIDTH result.
  - overflow = c_msb_in ^ carry_out.
- Reset (async assert, synchronous release into clk domain by the system):
  - All v[k] = 0, out_valid = 0, sum = 0, carry_out = 0, overflow = 0, zero = 0.
  - in_ready = 1 once rst_n is high.
- Reset mid-operation: in-flight operations are discarded. No result from before reset ever appears afterwards.
- Boundary values, all with sub = 0, carry_in = 1:
  - All-ones + all-zeros gives a carry propagating through every segment: sum = 0, carry_out = 1.
- SEGS = 1: degenerate single-stage registered adder, latency 1. Must be legal.

Decomposition:
- Package cla_pkg holds:
  - GROUP_W = 4
  - function group_pg(p[3:0], g[3:0]) returning {P_group, G_group}
  - function carry4(p, g, cin) returning carries[4:0]
- Sub-module cla_segment: combinational SEG_W-bit two-level lookahead.
  - Inputs: a, b, cin.
  - Outputs: sum, cout, c_msb_in.
  - Instantiated once per pipeline stage by generate.
- Top level contains only the stage registers, skew and handshake logic.

Test Plan:
1. WIDTH=64, SEGS=4: a=FFFF_FFFF_FFFF_FFFF, b=0000_0000_0000_0001, carry_in=0, sub=0 -> 4 cycles later sum=0, carry_out=1, zero=1, overflow=0.
2. a=5, b=7, carry_in=0, sub=1 -> sum=FFFF_FFFF_FFFF_FFFE, carry_out=0, overflow=0, zero=0. Also a=7, b=7, carry_in=0, sub=1 -> sum=0, carry_out=1, zero=1.
3. a=7FFF_FFFF_FFFF_FFFF, b=1, sub=0 -> sum=8000_0000_0000_0000, overflow=1, carry_out=0. Also a=8000_0000_0000_0000, b=1, carry_in=0, sub=1 -> overflow=1.
4. 200 back-to-back random operations with out_ready=1 -> out_valid high every cycle after a 4-cycle fill, results match the reference model in order. Repeat with SEGS=1 and SEGS=2.
5. Continuous input, out_ready=0 for 10 cycles -> exactly 4 operations accepted, then in_ready=0. sum and flags stable throughout. On out_ready=1, all results drain in order with no loss or duplicate.
6. 3 operations in flight, rst_n pulsed low mid-cycle -> out_valid=0 immediately (asynchronous). After release no stale results appear, and a new operation returns after exactly 4 cycles.

Source files
------------

// File: rtl/cla_pkg.sv
// Shared constants and 4-bit lookahead primitives for the pipelined CLA adder.
package cla_pkg;

  localparam int unsigned GROUP_W = 4;

  // Group propagate/generate over one 4-bit group, returned as {P_group, G_group}.
  function automatic logic [1:0] group_pg(input logic [3:0] p, input logic [3:0] g);
    logic pg;
    logic gg;
    pg = &p;
    gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    return {pg, gg};
  endfunction

  // Flat lookahead carries for one 4-bit group; c[0] is the group carry-in.
  function automatic logic [4:0] carry4(input logic [3:0] p, input logic [3:0] g,
                                        input logic cin);
    logic [4:0] c;
    c[0] = cin;
    c[1] = g[0] | (p[0] & cin);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]) |
           (&p & cin);
    return c;
  endfunction

endpackage

// File: rtl/cla_segment.sv
// Combinational SEG_W-bit two-level carry-lookahead adder slice.
module cla_segment
  import cla_pkg::*;
#(
  parameter int unsigned SEG_W = 16
) (
  input  logic [SEG_W-1:0] a,
  input  logic [SEG_W-1:0] b,
  input  logic             cin,
  output logic [SEG_W-1:0] sum,
  output logic             cout,
  output logic             c_msb_in
);

  localparam int unsigned NumGroups = SEG_W / GROUP_W;

  logic [SEG_W-1:0]     p;
  logic [SEG_W-1:0]     g;
  logic [SEG_W-1:0]     c_bit;
  logic [NumGroups-1:0] grp_p;
  logic [NumGroups-1:0] grp_g;
  logic [NumGroups:0]   grp_c;
  // Each group's own carry-out duplicates the second-level carry into the next group.
  logic [NumGroups-1:0] unused_grp_cout;

  assign p = a ^ b;
  assign g = a & b;

  // First level: propagate/generate per 4-bit group.
  always_comb begin
    grp_p = '0;
    grp_g = '0;
    for (int j = 0; j < NumGroups; j++) begin
      {grp_p[j], grp_g[j]} = group_pg(p[j*GROUP_W +: GROUP_W], g[j*GROUP_W +: GROUP_W]);
    end
  end

  // Second level: every group carry is a flat sum of products, so nothing ripples.
  always_comb begin
    logic term;
    grp_c    = '0;
    grp_c[0] = cin;
    for (int j = 1; j <= NumGroups; j++) begin
      for (int i = 0; i < j; i++) begin
        term = grp_g[i];
        for (int m = i + 1; m < j; m++) term = term & grp_p[m];
        grp_c[j] = grp_c[j] | term;
      end
      term = cin;
      for (int m = 0; m < j; m++) term = term & grp_p[m];
      grp_c[j] = grp_c[j] | term;
    end
  end

  // Bit carries inside each group from that group's lookahead carry-in.
  always_comb begin
    logic [4:0] c4;
    c_bit           = '0;
    unused_grp_cout = '0;
    for (int j = 0; j < NumGroups; j++) begin
      c4 = carry4(p[j*GROUP_W +: GROUP_W], g[j*GROUP_W +: GROUP_W], grp_c[j]);
      c_bit[j*GROUP_W +: GROUP_W] = c4[3:0];
      unused_grp_cout[j]          = c4[4];
    end
  end

  assign sum      = p ^ c_bit;
  assign cout     = grp_c[NumGroups];
  assign c_msb_in = c_bit[SEG_W-1];

endmodule

// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-lookahead adder/subtractor: one segment per stage, elastic handshake.
module pipelined_cla_adder #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned SEGS  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero
);

  localparam int unsigned SegW = WIDTH / SEGS;

  logic [SEGS-1:0]  v_q;
  logic [SEGS-1:0]  v_d;
  logic [SEGS-1:0]  v_prev;
  logic [SEGS-1:0]  adv;
  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;

  assign b_eff   = sub ? ~b : b;
  assign cin_eff = sub ? ~carry_in : carry_in;

  // A stage advances unless it and every stage after it are full and the output is stalled.
  always_comb begin
    logic all_full;
    all_full = 1'b1;
    adv      = '0;
    for (int k = int'(SEGS) - 1; k >= 0; k--) begin
      all_full = all_full & v_q[k];
      adv[k]   = out_ready | ~all_full;
    end
  end

  assign in_ready  = adv[0];
  assign v_prev    = SEGS'({v_q, in_valid});
  assign v_d       = (v_q & ~adv) | (v_prev & adv);
  assign out_valid = v_q[SEGS-1];

  // Valid bits; reset discards everything in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) v_q <= '0;
    else        v_q <= v_d;
  end

  for (genvar k = 0; k < SEGS; k++) begin : g_stage
    localparam int unsigned SrcW  = WIDTH - k * SegW;
    localparam int unsigned DoneW = (k + 1) * SegW;

    // Operands still to add, with this stage's segment in the low bits.
    logic [SrcW-1:0]  a_src;
    logic [SrcW-1:0]  b_src;
    logic             c_src;
    logic [SegW-1:0]  seg_sum;
    logic             seg_cout;
    logic             seg_c_msb;
    logic [DoneW-1:0] res_d;
    logic [DoneW-1:0] res_q;
    logic             c_q;

    if (k == 0) begin : g_first
      assign a_src = a;
      assign b_src = b_eff;
      assign c_src = cin_eff;
      assign res_d = seg_sum;
    end else begin : g_next
      assign a_src = g_stage[k-1].g_rem.a_q;
      assign b_src = g_stage[k-1].g_rem.b_q;
      assign c_src = g_stage[k-1].c_q;
      assign res_d = {seg_sum, g_stage[k-1].res_q};
    end

    cla_segment #(
      .SEG_W (SegW)
    ) u_seg (
      .a        (a_src[SegW-1:0]),
      .b        (b_src[SegW-1:0]),
      .cin      (c_src),
      .sum      (seg_sum),
      .cout     (seg_cout),
      .c_msb_in (seg_c_msb)
    );

    // Completed low result bits and the segment carry that crosses into the next stage.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        res_q <= '0;
        c_q   <= 1'b0;
      end else if (adv[k]) begin
        res_q <= res_d;
        c_q   <= seg_cout;
      end
    end

    if (k < SEGS - 1) begin : g_rem
      logic [SrcW-SegW-1:0] a_q;
      logic [SrcW-SegW-1:0] b_q;
      logic                 unused_c_msb;

      assign unused_c_msb = seg_c_msb;

      // Skew: operand bits not yet added travel down with the partial result.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
        end else if (adv[k]) begin
          a_q <= a_src[SrcW-1:SegW];
          b_q <= b_src[SrcW-1:SegW];
        end
      end
    end else begin : g_last
      logic ovf_q;
      logic zero_q;

      // Flags are registered alongside the final sum so they stall with it.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ovf_q  <= 1'b0;
          zero_q <= 1'b0;
        end else if (adv[k]) begin
          ovf_q  <= seg_c_msb ^ seg_cout;
          zero_q <= (res_d == '0);
        end
      end

      assign sum       = res_q;
      assign carry_out = c_q;
      assign overflow  = ovf_q;
      assign zero      = zero_q;
    end
  end

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Self-checking bench: directed vectors, random streams on SEGS=4/2/1, stalls and reset.
module tb_pipelined_cla_adder;

  localparam int unsigned W    = 64;
  localparam int unsigned W1   = W + 1;
  localparam int unsigned W3   = W + 3;
  localparam int          NDut = 3;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         zero;
    logic [31:0]  t;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            in_valid;
  logic            out_ready;
  logic            carry_in;
  logic            sub;
  logic [W-1:0]    a;
  logic [W-1:0]    b;
  logic [NDut-1:0] in_ready_w;
  logic [NDut-1:0] out_valid_w;
  logic [NDut-1:0] carry_w;
  logic [NDut-1:0] ovf_w;
  logic [NDut-1:0] zero_w;
  logic [W-1:0]    sum_w [NDut];

  exp_t            exp_q [NDut][$];
  int              err_cnt = 0;
  int              chk_cnt = 0;
  int unsigned     cyc = 0;
  int unsigned     pushes = 0;
  int unsigned     str_lo = 0;
  int unsigned     str_hi = 0;
  logic [NDut-1:0] act = '0;
  bit              lat_chk = 1'b0;
  bit              stream_on = 1'b0;

  always #5 clk = ~clk;

  for (genvar d = 0; d < NDut; d++) begin : g_dut
    pipelined_cla_adder #(
      .WIDTH (W),
      .SEGS  (d == 0 ? 4 : (d == 1 ? 2 : 1))
    ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready_w[d]),
      .a         (a),
      .b         (b),
      .carry_in  (carry_in),
      .sub       (sub),
      .out_valid (out_valid_w[d]),
      .out_ready (out_ready),
      .sum       (sum_w[d]),
      .carry_out (carry_w[d]),
      .overflow  (ovf_w[d]),
      .zero      (zero_w[d])
    );
  end

  function automatic int unsigned segs_of(input int d);
    return (d == 0) ? 4 : ((d == 1) ? 2 : 1);
  endfunction

  task automatic check_eq(input string tag, input logic [W3-1:0] got, input logic [W3-1:0] want);
    chk_cnt++;
    if (got !== want) begin
      err_cnt++;
      $display("FAIL %s: got %h, want %h", tag, got, want);
    end
  endtask

  // Reference: {sum, carry_out, overflow, zero} from plain integer arithmetic.
  function automatic logic [W+2:0] ref_op(input logic [W-1:0] x, input logic [W-1:0] y,
                                          input logic c, input logic s);
    logic [W-1:0]        r;
    logic [W:0]          t;
    logic                co;
    logic                ov;
    logic signed [W+1:0] sx;
    logic signed [W+1:0] sy;
    logic signed [W+1:0] sc;
    logic signed [W+1:0] sr;
    sx = {{2{x[W-1]}}, x};
    sy = {{2{y[W-1]}}, y};
    sc = {{(W + 1){1'b0}}, c};
    if (!s) begin
      t  = {1'b0, x} + {1'b0, y} + W1'(c);
      r  = t[W-1:0];
      co = t[W];
      sr = sx + sy + sc;
    end else begin
      r  = x - y - W'(c);
      co = ({1'b0, x} >= ({1'b0, y} + W1'(c)));  // no borrow
      sr = sx - sy - sc;
    end
    ov = !((sr[W+1:W-1] == 3'b000) || (sr[W+1:W-1] == 3'b111));
    return {r, co, ov, (r == '0)};
  endfunction

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 7))
      0:       return '1;
      1:       return '0;
      2:       return {1'b0, {(W - 1){1'b1}}};
      3:       return {1'b1, {(W - 1){1'b0}}};
      default: return {$urandom, $urandom};
    endcase
  endfunction

  task automatic set_rand();
    a        = pick();
    b        = pick();
    carry_in = 1'($urandom_range(0, 1));
    sub      = 1'($urandom_range(0, 1));
  endtask

  // One clock: score outputs and inputs of active DUTs, then advance to the next negedge.
  task automatic cycle();
    exp_t e;
    #1;
    for (int d = 0; d < NDut; d++) begin
      if (act[d]) begin
        if (out_valid_w[d] && out_ready) begin
          check_eq($sformatf("out_expected_d%0d", d), W3'(exp_q[d].size() != 0), 1);
          if (exp_q[d].size() != 0) begin
            e = exp_q[d].pop_front();
            check_eq($sformatf("result_d%0d", d),
                     {sum_w[d], carry_w[d], ovf_w[d], zero_w[d]}, {e.sum, e.cout, e.ovf, e.zero});
            if (lat_chk) check_eq($sformatf("latency_d%0d", d), W3'(cyc - e.t), W3'(segs_of(d)));
          end
        end else if (out_valid_w[d] && !out_ready && exp_q[d].size() != 0) begin
          e = exp_q[d][0];
          check_eq($sformatf("hold_d%0d", d),
                   {sum_w[d], carry_w[d], ovf_w[d], zero_w[d]}, {e.sum, e.cout, e.ovf, e.zero});
        end
        if (stream_on && cyc >= str_lo + segs_of(d) && cyc < str_hi + segs_of(d))
          check_eq($sformatf("stream_valid_d%0d", d), W3'(out_valid_w[d]), 1);
        if (in_valid && in_ready_w[d]) begin
          {e.sum, e.cout, e.ovf, e.zero} = ref_op(a, b, carry_in, sub);
          e.t = cyc;
          exp_q[d].push_back(e);
          if (d == 0) pushes++;
        end
      end
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic drain(input string tag);
    int n;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while ((exp_q[0].size() + exp_q[1].size() + exp_q[2].size()) != 0 && n < 20) begin
      cycle();
      n++;
    end
    for (int d = 0; d < NDut; d++)
      if (act[d]) check_eq($sformatf("%s_left_d%0d", tag, d), W3'(exp_q[d].size()), 0);
  endtask

  task automatic do_reset();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    rst_n     = 1'b0;
    repeat (2) @(negedge clk);
    for (int d = 0; d < NDut; d++) exp_q[d].delete();
    rst_n = 1'b1;
  endtask

  // Single operation on the SEGS=4 instance against a hand-derived expectation.
  task automatic directed(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic c, input logic s, input logic [W+2:0] want);
    int unsigned n;
    a = x; b = y; carry_in = c; sub = s;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    #1 check_eq({tag, "_in_ready"}, W3'(in_ready_w[0]), 1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    n = 1;
    #1;
    while (!out_valid_w[0] && n < 10) begin
      @(posedge clk);
      @(negedge clk);
      n++;
      #1;
    end
    check_eq({tag, "_latency"}, W3'(n), 4);
    check_eq(tag, {sum_w[0], carry_w[0], ovf_w[0], zero_w[0]}, want);
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; carry_in = 1'b0; sub = 1'b0;
    @(negedge clk);
    #1;
    for (int d = 0; d < NDut; d++) begin
      check_eq($sformatf("rst_valid_d%0d", d), W3'(out_valid_w[d]), 0);
      check_eq($sformatf("rst_outs_d%0d", d), {sum_w[d], carry_w[d], ovf_w[d], zero_w[d]}, 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1 check_eq("rst_in_ready", W3'(in_ready_w[0]), 1);
    @(negedge clk);

    // Directed vectors: {sum, carry_out, overflow, zero}.
    directed("ones_plus_one", '1, 64'd1, 1'b0, 1'b0, {64'h0, 1'b1, 1'b0, 1'b1});
    directed("five_minus_seven", 64'd5, 64'd7, 1'b0, 1'b1,
             {64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 1'b0});
    directed("seven_minus_seven", 64'd7, 64'd7, 1'b0, 1'b1, {64'h0, 1'b1, 1'b0, 1'b1});
    directed("maxpos_plus_one", 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0,
             {64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b0});
    directed("minneg_minus_one", 64'h8000_0000_0000_0000, 64'd1, 1'b0, 1'b1,
             {64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 1'b0});
    directed("ones_plus_zero_cin", '1, 64'd0, 1'b1, 1'b0, {64'h0, 1'b1, 1'b0, 1'b1});

    // Back-to-back stream on all three depths.
    do_reset();
    act = '1; lat_chk = 1'b1; stream_on = 1'b1;
    str_lo = cyc; str_hi = cyc + 200;
    repeat (200) begin
      set_rand();
      in_valid = 1'b1;
      cycle();
    end
    drain("stream");
    stream_on = 1'b0;

    // Backpressure on the SEGS=4 instance.
    do_reset();
    act = 3'b001; lat_chk = 1'b0; pushes = 0;
    out_ready = 1'b0;
    repeat (10) begin
      set_rand();
      in_valid = 1'b1;
      cycle();
    end
    check_eq("stall_accepted", W3'(pushes), 4);
    #1 check_eq("stall_in_ready", W3'(in_ready_w[0]), 0);
    out_ready = 1'b1;
    repeat (6) begin
      set_rand();
      in_valid = 1'b1;
      cycle();
    end
    check_eq("full_pipe_throughput", W3'(pushes), 10);
    repeat (150) begin
      set_rand();
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end
    drain("backpressure");

    // Reset with operations in flight.
    out_ready = 1'b0;
    repeat (5) begin
      set_rand();
      in_valid = 1'b1;
      cycle();
    end
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1 check_eq("async_rst_valid", W3'(out_valid_w[0]), 0);
    exp_q[0].delete();
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    repeat (8) begin
      cycle();
      #1 check_eq("no_stale", W3'(out_valid_w[0]), 0);
    end
    lat_chk = 1'b1;
    set_rand();
    in_valid = 1'b1;
    cycle();
    drain("after_reset");

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
